ai_window_loader: RTL and testbench
===================================

// Module: ai_window_loader
// PURPOSE
//  Parametrised successor loader for the AI comparer. It keeps a sliding window of
//  WIN input stream samples and fetches one REF_N-byte reference word from the
//  coefficient RAM per sample. It emits a packed {reference, window} vector per
//  sample over a valid/ready handshake with output hold. Sits between the feature
//  stream source and the comparer datapath.
// PARAMETERS
//  SAMPLE_W  8   bits per stream sample and per reference byte
//  WIN       3   stream window taps; odd, >=3; centre tap = current sample
//  REF_N     4   reference bytes per RAM word
//  ADDR_W    16  c_ram_addr width
//  CNT_W     15  sample counter / sample_size width; CNT_W < ADDR_W
// PORTS
//  clk           in   1                     clock; single clock domain
//  rst           in   1                     synchronous reset, active-high
//  init          in   1                     synchronous frame restart (soft clear)
//  compress      in   1                     1: one RAM word per sample; 0: one word per 2 samples
//  sample_size   in   CNT_W                 last counter index of a frame
//  stream_in     in   SAMPLE_W              input sample
//  stream_rdy    in   1                     stream_in valid; accepted only when stream_ready=1
//  stream_ready  out  1                     loader can accept a sample this cycle
//  c_ram_addr    out  ADDR_W                reference RAM word address
//  c_ram_read    out  1                     read request; held until c_ram_rdy
//  c_ram_rdy     in   1                     c_ram_data valid this cycle
//  c_ram_data    in   REF_N*SAMPLE_W        reference word; byte 0 in LSBs
//  data_out      out  (REF_N+WIN)*SAMPLE_W  {ref byte REF_N-1..0, win tap WIN-1..0}
//  out_valid     out  1                     data_out valid
//  out_ready     in   1                     consumer accepts data_out
//  frame_end     out  1                     qualifies data_out: last vector of frame
// BEHAVIOUR
//  - Reset: all outputs 0; window, ref word, counter, fill count cleared; state IDLE.
//  - States: IDLE -> FETCH -> (FILL: IDLE | else EMIT) -> IDLE.
//  - IDLE: stream_ready=1. On stream_rdy: shift window (tap0 <- stream_in,
//    tap k <- tap k-1), go to FETCH.
//  - FETCH: c_ram_read=1 with c_ram_addr = compress ? counter : counter>>1, both
//    zero-extended and stable until c_ram_rdy. On c_ram_rdy: latch c_ram_data.
//      - Fill phase (fill count < (WIN-1)/2): counter++, fill count++, go to IDLE,
//        no output.
//      - Otherwise: go to EMIT.
//  - EMIT: registered data_out/out_valid/frame_end; out_valid rises 1 cycle after
//    c_ram_rdy. data_out, frame_end and out_valid are held stable until out_ready.
//    frame_end = (counter == sample_size).
//      - On out_valid & out_ready with frame_end=1: counter=0, window cleared,
//        fill count=0, so the next frame refills.
//      - On out_valid & out_ready otherwise: counter++.
//      - In both cases out_valid drops next cycle and state goes to IDLE.
//  - Throughput: at most 1 vector per 3 cycles when RAM answers in 1 cycle.
//  - Counter is CNT_W bits. sample_size = 2^CNT_W-1 wraps naturally; sample_size=0
//    means every emitted vector has frame_end=1.
//  - stream_rdy outside IDLE is ignored. The source must hold it (not lost-sample
//    tolerant).
//  - init (any state): same clears as reset except outputs; the state goes to IDLE;
//    an outstanding RAM read is abandoned (c_ram_read=0 next cycle; a late
//    c_ram_rdy is ignored); out_valid=0 next cycle. init with stream_rdy: init wins,
//    the sample is dropped, stream_ready=0 that cycle.
//  - rst has priority over init. rst mid-FETCH/EMIT behaves as init plus output clear.
//  - c_ram_addr/c_ram_read: combinational from state/counter. They are 0 outside FETCH.
// STRUCTURE
//  - Shared package ai_pkg: state enum (IDLE, FETCH, EMIT), SAMPLE_W default,
//    address-mapping function addr_of(counter, compress).
//  - Sub-module ai_tap_window #(SAMPLE_W, WIN): shift register with shift and clear
//    inputs and a flat tap output. The FSM, counter, RAM port and output register
//    stay in the top.
// TESTING
//  1. rst, WIN=3, compress=1, sample_size=3. Samples 0x11,0x22,0x33,0x44,0x55;
//     RAM word n = {n,n,n,n}.
//     -> the first sample gives no output. The first vector has ref=0x01010101,
//        win={0x00,0x11,0x22}. frame_end is set on the vector at counter=3.
//  2. compress=0, 6 samples, counters 0..5 -> c_ram_addr sequence 0,0,1,1,2,2.
//  3. Hold out_ready=0 for 10 cycles in EMIT -> data_out/frame_end unchanged,
//     stream_ready=0, no RAM read. One cycle of out_ready -> a single transfer.
//  4. Frame wrap at sample_size=1 -> after frame_end the window reads zero, the
//     next sample is fill-only, and the counter restarts at 0 (addr 0).
//  5. init while c_ram_read is pending, then a stray c_ram_rdy -> no out_valid,
//     counter 0, and the next accepted sample is treated as fill.
//  6. WIN=5, REF_N=2: 2 fill samples, then data_out width 56 with
//     taps {s0..s4} correctly ordered.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared types and helpers for the AI comparer window loader.
// Holds the loader state encoding and the counter-to-RAM-word address mapping.
package ai_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } ai_state_e;

  localparam int AI_SAMPLE_W   = 8;
  localparam int AI_ADDR_MAX_W = 32;

  // Uncompressed frames share one reference word between two consecutive samples.
  function automatic logic [AI_ADDR_MAX_W-1:0] addr_of(
    input logic [AI_ADDR_MAX_W-1:0] counter,
    input logic                     compress
  );
    return compress ? counter : (counter >> 1);
  endfunction

endpackage

// File: rtl/ai_tap_window.sv
// Sliding window of WIN stream samples; tap 0 holds the newest sample.
// Flat output packs tap k into bits [k*SAMPLE_W +: SAMPLE_W].
module ai_tap_window #(
  parameter int SAMPLE_W = 8,
  parameter int WIN      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    shift,
  input  logic [SAMPLE_W-1:0]     din,
  output logic [WIN*SAMPLE_W-1:0] taps
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      taps <= '0;
    end else if (shift) begin
      taps <= {taps[(WIN-1)*SAMPLE_W-1:0], din};
    end
  end

endmodule

// File: rtl/ai_window_loader.sv
// Loader feeding the AI comparer: keeps a sample window, fetches one reference
// word per sample and emits {reference, window} vectors over valid/ready.
//
// state | meaning
// IDLE  | waiting for a stream sample (stream_ready=1)
// FETCH | reference RAM read outstanding for the current counter
// EMIT  | data_out valid, held until out_ready
module ai_window_loader
  import ai_pkg::*;
#(
  parameter int SAMPLE_W = AI_SAMPLE_W,
  parameter int WIN      = 3,
  parameter int REF_N    = 4,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            init,
  input  logic                            compress,
  input  logic [CNT_W-1:0]                sample_size,
  input  logic [SAMPLE_W-1:0]             stream_in,
  input  logic                            stream_rdy,
  output logic                            stream_ready,
  output logic [ADDR_W-1:0]               c_ram_addr,
  output logic                            c_ram_read,
  input  logic                            c_ram_rdy,
  input  logic [REF_N*SAMPLE_W-1:0]       c_ram_data,
  output logic [(REF_N+WIN)*SAMPLE_W-1:0] data_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_end
);

  localparam int WIN_BITS = WIN * SAMPLE_W;
  localparam int OUT_BITS = (REF_N + WIN) * SAMPLE_W;
  localparam int FILL_N   = (WIN - 1) / 2;
  localparam int FILL_W   = $clog2(FILL_N + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_N);

  ai_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [FILL_W-1:0]    fill_q;
  logic [OUT_BITS-1:0]  data_q;
  logic                 valid_q, valid_d;
  logic                 fend_q;
  logic [WIN_BITS-1:0]  taps;

  logic win_shift, win_clear;
  logic cnt_inc, cnt_clr, fill_inc, fill_clr, load_out;

  ai_tap_window #(
    .SAMPLE_W (SAMPLE_W),
    .WIN      (WIN)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .clear (win_clear),
    .shift (win_shift),
    .din   (stream_in),
    .taps  (taps)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    win_shift = 1'b0;
    win_clear = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    fill_inc  = 1'b0;
    fill_clr  = 1'b0;
    load_out  = 1'b0;
    if (init) begin
      // Soft restart: abandons any read in flight and drops the pending vector.
      state_d   = IDLE;
      valid_d   = 1'b0;
      win_clear = 1'b1;
      cnt_clr   = 1'b1;
      fill_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (stream_rdy) begin
            win_shift = 1'b1;
            state_d   = FETCH;
          end
        end
        FETCH: begin
          if (c_ram_rdy) begin
            if (fill_q < FILL_LAST) begin
              cnt_inc  = 1'b1;
              fill_inc = 1'b1;
              state_d  = IDLE;
            end else begin
              load_out = 1'b1;
              valid_d  = 1'b1;
              state_d  = EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
            if (fend_q) begin
              cnt_clr   = 1'b1;
              win_clear = 1'b1;
              fill_clr  = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fill_clr) begin
        fill_q <= '0;
      end else if (fill_inc) begin
        fill_q <= fill_q + 1'b1;
      end
      if (load_out) begin
        data_q <= {c_ram_data, taps};
        fend_q <= (cnt_q == sample_size);
      end
    end
  end

  assign stream_ready = (state_q == IDLE) && !init && !rst;
  assign c_ram_read   = (state_q == FETCH);
  assign c_ram_addr   = (state_q == FETCH)
                        ? ADDR_W'(addr_of(AI_ADDR_MAX_W'(cnt_q), compress))
                        : '0;
  assign data_out     = data_q;
  assign out_valid    = valid_q;
  assign frame_end    = fend_q;

endmodule

// File: tb/tb_ai_window_loader.sv
// Bench for ai_window_loader: default WIN=3/REF_N=4 instance plus a WIN=5/REF_N=2 instance.
module tb_ai_window_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        compress = 1'b1;
  logic [14:0] sample_size = 15'd3;
  logic [7:0]  stream_in = 8'h00;
  logic        stream_rdy = 1'b0;
  logic        stream_ready;
  logic [15:0] c_ram_addr;
  logic        c_ram_read;
  logic        c_ram_rdy = 1'b0;
  logic [31:0] c_ram_data = '0;
  logic [55:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_end;

  logic        b_init = 1'b0;
  logic        b_compress = 1'b1;
  logic [14:0] b_sample_size = 15'd100;
  logic [7:0]  b_stream_in = 8'h00;
  logic        b_stream_rdy = 1'b0;
  logic        b_stream_ready;
  logic [15:0] b_c_ram_addr;
  logic        b_c_ram_read;
  logic        b_c_ram_rdy = 1'b0;
  logic [15:0] b_c_ram_data = '0;
  logic [55:0] b_data_out;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_frame_end;

  ai_window_loader dut (
    .clk(clk), .rst(rst), .init(init), .compress(compress), .sample_size(sample_size),
    .stream_in(stream_in), .stream_rdy(stream_rdy), .stream_ready(stream_ready),
    .c_ram_addr(c_ram_addr), .c_ram_read(c_ram_read), .c_ram_rdy(c_ram_rdy),
    .c_ram_data(c_ram_data), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .frame_end(frame_end)
  );

  ai_window_loader #(.WIN(5), .REF_N(2)) dut_b (
    .clk(clk), .rst(rst), .init(b_init), .compress(b_compress), .sample_size(b_sample_size),
    .stream_in(b_stream_in), .stream_rdy(b_stream_rdy), .stream_ready(b_stream_ready),
    .c_ram_addr(b_c_ram_addr), .c_ram_read(b_c_ram_read), .c_ram_rdy(b_c_ram_rdy),
    .c_ram_data(b_c_ram_data), .data_out(b_data_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .frame_end(b_frame_end)
  );

  // Reference RAM: word n = n replicated in every byte, answered within the read's first cycle.
  logic ram_auto  = 1'b1;
  logic stray_rdy = 1'b0;
  always @(negedge clk) begin
    c_ram_rdy    = ram_auto ? c_ram_read : stray_rdy;
    c_ram_data   = {4{c_ram_addr[7:0]}};
    b_c_ram_rdy  = b_c_ram_read;
    b_c_ram_data = {2{b_c_ram_addr[7:0]}};
  end

  logic [55:0] out_log[$];
  logic        fe_log[$];
  logic [15:0] addr_log[$];
  logic [55:0] b_out_log[$];
  always @(posedge clk) begin
    if (out_valid === 1'b1 && out_ready) begin
      out_log.push_back(data_out);
      fe_log.push_back(frame_end);
    end
    if (c_ram_read === 1'b1 && c_ram_rdy) addr_log.push_back(c_ram_addr);
    if (b_out_valid === 1'b1 && b_out_ready) b_out_log.push_back(b_data_out);
  end

  // Behavioural model of the WIN=3 instance; fills the scoreboard as samples are driven.
  logic [7:0]  m_win[3];
  logic [14:0] m_cnt;
  int          m_fill;
  logic [55:0] exp_data[$];
  logic        exp_fe[$];
  logic [15:0] exp_addr[$];
  logic [55:0] b_exp[$];

  task automatic model_reset();
    m_win[0] = 8'h00; m_win[1] = 8'h00; m_win[2] = 8'h00;
    m_cnt = '0;
    m_fill = 0;
  endtask

  task automatic clear_exp();
    exp_data.delete();
    exp_fe.delete();
    exp_addr.delete();
  endtask

  task automatic model_push(input logic [7:0] s);
    logic [15:0] a;
    logic        fe;
    a = compress ? {1'b0, m_cnt} : {2'b00, m_cnt[14:1]};
    exp_addr.push_back(a);
    m_win[2] = m_win[1];
    m_win[1] = m_win[0];
    m_win[0] = s;
    if (m_fill < 1) begin
      m_fill++;
      m_cnt++;
    end else begin
      exp_data.push_back({{4{a[7:0]}}, m_win[2], m_win[1], m_win[0]});
      fe = (m_cnt == sample_size);
      exp_fe.push_back(fe);
      if (fe) model_reset();
      else m_cnt++;
    end
  endtask

  task automatic drive_raw(input logic [7:0] s);
    int i;
    i = 0;
    while (stream_ready !== 1'b1 && i < 100) begin @(negedge clk); i++; end
    if (stream_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL stream_ready_timeout got=%b need=1", stream_ready);
    end
    stream_in = s;
    stream_rdy = 1'b1;
    @(negedge clk);
    stream_rdy = 1'b0;
  endtask

  task automatic feed(input logic [7:0] s);
    model_push(s);
    drive_raw(s);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (stream_ready !== 1'b1 && i < 100) begin @(negedge clk); i++; end
    if (stream_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL idle_timeout got=%b need=1", stream_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_exp();
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL reset_stream_ready got=%b need=0", stream_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b need=0", out_valid); end
    total++; if (data_out !== 56'h0) begin bad++; $display("FAIL reset_data_out got=%h need=0", data_out); end
    total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset_frame_end got=%b need=0", frame_end); end
    total++; if (c_ram_read !== 1'b0 || c_ram_addr !== 16'h0) begin
      bad++; $display("FAIL reset_ram got read=%b addr=%h need 0/0", c_ram_read, c_ram_addr);
    end
    rst = 1'b0;
    model_reset();
    clear_exp();
    #1;
    total++; if (stream_ready !== 1'b1) begin bad++; $display("FAIL post_reset_stream_ready got=%b need=1", stream_ready); end
  endtask

  task automatic test_basic();
    int ob, ab, k;
    logic [55:0] e;
    logic [15:0] ea;
    compress = 1'b1;
    sample_size = 15'd3;
    ob = out_log.size();
    ab = addr_log.size();
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44); feed(8'h55);
    wait_idle();
    total++; if (out_log.size() - ob != 3) begin bad++; $display("FAIL basic_count got=%0d need=3", out_log.size() - ob); end
    total++; if (out_log[ob] !== {32'h01010101, 8'h00, 8'h11, 8'h22}) begin
      bad++; $display("FAIL basic_first got=%h need=%h", out_log[ob], {32'h01010101, 8'h00, 8'h11, 8'h22});
    end
    total++; if (fe_log[ob] !== 1'b0 || fe_log[ob+1] !== 1'b0 || fe_log[ob+2] !== 1'b1) begin
      bad++; $display("FAIL basic_frame_end got=%b%b%b need=001", fe_log[ob], fe_log[ob+1], fe_log[ob+2]);
    end
    k = 0;
    while (exp_data.size() > 0) begin
      e = exp_data.pop_front();
      total++; if (out_log[ob+k] !== e || fe_log[ob+k] !== exp_fe.pop_front()) begin
        bad++; $display("FAIL basic_vec%0d got=%h fe=%b need=%h", k, out_log[ob+k], fe_log[ob+k], e);
      end
      k++;
    end
    k = 0;
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      total++; if (addr_log[ab+k] !== ea) begin bad++; $display("FAIL basic_addr%0d got=%h need=%h", k, addr_log[ab+k], ea); end
      k++;
    end
  endtask

  task automatic test_compress0();
    int ob, ab, k;
    logic [55:0] e;
    logic [15:0] addr_ref[6];
    addr_ref = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};
    do_reset();
    compress = 1'b0;
    sample_size = 15'd100;
    ob = out_log.size();
    ab = addr_log.size();
    for (int i = 0; i < 6; i++) feed(8'hA0 + 8'(i));
    wait_idle();
    total++; if (addr_log.size() - ab != 6) begin bad++; $display("FAIL c0_addr_count got=%0d need=6", addr_log.size() - ab); end
    for (int i = 0; i < 6; i++) begin
      total++; if (addr_log[ab+i] !== addr_ref[i] || exp_addr.pop_front() !== addr_ref[i]) begin
        bad++; $display("FAIL c0_addr%0d got=%h need=%h", i, addr_log[ab+i], addr_ref[i]);
      end
    end
    total++; if (out_log.size() - ob != 5) begin bad++; $display("FAIL c0_count got=%0d need=5", out_log.size() - ob); end
    k = 0;
    while (exp_data.size() > 0) begin
      e = exp_data.pop_front();
      total++; if (out_log[ob+k] !== e || fe_log[ob+k] !== exp_fe.pop_front()) begin
        bad++; $display("FAIL c0_vec%0d got=%h need=%h", k, out_log[ob+k], e);
      end
      k++;
    end
  endtask

  task automatic test_hold();
    int i, ob;
    logic [55:0] d0, e;
    logic        f0;
    out_ready = 1'b0;
    feed(8'hB0);
    i = 0;
    while (out_valid !== 1'b1 && i < 50) begin @(negedge clk); i++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid_timeout got=%b need=1", out_valid); end
    d0 = data_out;
    f0 = frame_end;
    e = exp_data.pop_front();
    total++; if (d0 !== e || f0 !== exp_fe.pop_front()) begin bad++; $display("FAIL hold_vec got=%h need=%h", d0, e); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (data_out !== d0 || frame_end !== f0 || out_valid !== 1'b1 || stream_ready !== 1'b0 || c_ram_read !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d got d=%h fe=%b v=%b sr=%b rd=%b need d=%h fe=%b v=1 sr=0 rd=0",
                 c, data_out, frame_end, out_valid, stream_ready, c_ram_read, d0, f0);
      end
    end
    ob = out_log.size();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drop_valid got=%b need=0", out_valid); end
    @(negedge clk);
    total++; if (out_log.size() - ob != 1) begin bad++; $display("FAIL hold_single_xfer got=%0d need=1", out_log.size() - ob); end
    out_ready = 1'b1;
    clear_exp();
  endtask

  task automatic test_wrap();
    int ob, ab, k;
    logic [55:0] e;
    do_reset();
    compress = 1'b1;
    sample_size = 15'd1;
    ob = out_log.size();
    ab = addr_log.size();
    feed(8'hC1); feed(8'hC2); feed(8'hC3); feed(8'hC4);
    wait_idle();
    total++; if (out_log[ob+1] !== {32'h01010101, 8'h00, 8'hC3, 8'hC4} || fe_log[ob+1] !== 1'b1) begin
      bad++; $display("FAIL wrap_refill got=%h fe=%b need=%h fe=1", out_log[ob+1], fe_log[ob+1], {32'h01010101, 8'h00, 8'hC3, 8'hC4});
    end
    total++; if (addr_log[ab+2] !== 16'h0) begin bad++; $display("FAIL wrap_restart_addr got=%h need=0", addr_log[ab+2]); end
    k = 0;
    while (exp_data.size() > 0) begin
      e = exp_data.pop_front();
      total++; if (out_log[ob+k] !== e || fe_log[ob+k] !== exp_fe.pop_front()) begin
        bad++; $display("FAIL wrap_vec%0d got=%h need=%h", k, out_log[ob+k], e);
      end
      k++;
    end
    total++; if (out_log.size() - ob != 2) begin bad++; $display("FAIL wrap_count got=%0d need=2", out_log.size() - ob); end
  endtask

  task automatic test_init();
    int ob, ab;
    do_reset();
    compress = 1'b1;
    sample_size = 15'd5;
    ram_auto = 1'b0;
    drive_raw(8'h61);
    @(negedge clk);
    total++; if (c_ram_read !== 1'b1 || c_ram_addr !== 16'h0) begin
      bad++; $display("FAIL init_pending got read=%b addr=%h need 1/0", c_ram_read, c_ram_addr);
    end
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    #1;
    total++; if (c_ram_read !== 1'b0 || stream_ready !== 1'b1) begin
      bad++; $display("FAIL init_abandon got read=%b sr=%b need 0/1", c_ram_read, stream_ready);
    end
    stray_rdy = 1'b1;
    repeat (2) @(negedge clk);
    stray_rdy = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0 || stream_ready !== 1'b1 || c_ram_read !== 1'b0) begin
      bad++; $display("FAIL init_stray got v=%b sr=%b rd=%b need 0/1/0", out_valid, stream_ready, c_ram_read);
    end
    ram_auto = 1'b1;
    init = 1'b1;
    stream_rdy = 1'b1;
    stream_in = 8'h99;
    #1;
    total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL init_blocks_ready got=%b need=0", stream_ready); end
    @(negedge clk);
    init = 1'b0;
    stream_rdy = 1'b0;
    model_reset();
    clear_exp();
    ob = out_log.size();
    ab = addr_log.size();
    feed(8'h71); feed(8'h72);
    wait_idle();
    total++; if (out_log.size() - ob != 1) begin bad++; $display("FAIL init_count got=%0d need=1", out_log.size() - ob); end
    total++; if (out_log[ob] !== {32'h01010101, 8'h00, 8'h71, 8'h72} || out_log[ob] !== exp_data.pop_front()) begin
      bad++; $display("FAIL init_vec got=%h need=%h", out_log[ob], {32'h01010101, 8'h00, 8'h71, 8'h72});
    end
    total++; if (addr_log[ab] !== exp_addr.pop_front() || addr_log[ab+1] !== exp_addr.pop_front()) begin
      bad++; $display("FAIL init_addr got=%h,%h need=0000,0001", addr_log[ab], addr_log[ab+1]);
    end
    clear_exp();
  endtask

  task automatic test_win5();
    int ob, i;
    logic [7:0]  s[5];
    logic [55:0] e;
    s = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    ob = b_out_log.size();
    for (int n = 0; n < 5; n++) begin
      if (n == 2) b_exp.push_back({16'h0202, 8'h00, 8'h00, s[0], s[1], s[2]});
      if (n == 3) b_exp.push_back({16'h0303, 8'h00, s[0], s[1], s[2], s[3]});
      if (n == 4) b_exp.push_back({16'h0404, s[0], s[1], s[2], s[3], s[4]});
      i = 0;
      while (b_stream_ready !== 1'b1 && i < 100) begin @(negedge clk); i++; end
      if (b_stream_ready !== 1'b1) begin
        total++; bad++; $display("FAIL win5_ready_timeout got=%b need=1", b_stream_ready);
      end
      b_stream_in = s[n];
      b_stream_rdy = 1'b1;
      @(negedge clk);
      b_stream_rdy = 1'b0;
    end
    i = 0;
    while (b_stream_ready !== 1'b1 && i < 100) begin @(negedge clk); i++; end
    @(negedge clk);
    total++; if (b_out_log.size() - ob != 3) begin bad++; $display("FAIL win5_count got=%0d need=3", b_out_log.size() - ob); end
    for (int k = 0; k < 3; k++) begin
      e = b_exp.pop_front();
      total++; if (b_out_log[ob+k] !== e) begin bad++; $display("FAIL win5_vec%0d got=%h need=%h", k, b_out_log[ob+k], e); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_compress0();
    test_hold();
    test_wrap();
    test_init();
    test_win5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running need=finished");
    $fatal(1, "timeout");
  end

endmodule
